// File: rtl/counter_slot_arbiter.sv
// counter_slot_arbiter
// Round-robin arbiter for one shared 3-bit counter slot among NREQ
// requesters. Grants are one-hot and registered. A grant ends on release
// or when the owner drops its request. Exactly one dead (GAP) cycle follows
// every grant.
//
// Optional feature macro: SLOT_TIMEOUT_EN
//   defined   - a grant is forced to end after MAX_HOLD cycles, and
//               timeout pulses during the following GAP cycle
//   undefined - grants last indefinitely and timeout is tied low
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   req           per-requester request level
//   owner_release current owner ends its grant; only honoured in GRANT.
//                 The name "release" is a reserved SystemVerilog keyword,
//                 so this port uses a different name.
//   gnt           one-hot grant
//   gnt_id        index of the current owner (0 when idle)
//   busy          high while a grant is active
//   hold_cnt      cycles spent in the current grant, saturates at 7
//   grant_cnt     number of grants issued, wraps modulo 8
//   timeout       one-cycle pulse after a forced release

module counter_slot_arbiter #(
  parameter int NREQ     = 6,
  parameter int MAX_HOLD = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            owner_release,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_id,
  output logic            busy,
  output logic [2:0]      hold_cnt,
  output logic [2:0]      grant_cnt,
  output logic            timeout
);

`ifdef SLOT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [2:0]      HOLD_LAST = 3'(MAX_HOLD - 1);
  localparam logic [2:0]      LAST_ID   = 3'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state, state_next;
  logic [2:0]      ptr, ptr_next;
  logic [NREQ-1:0] gnt_next;
  logic [2:0]      gnt_id_next;
  logic            busy_next;
  logic [2:0]      hold_next;
  logic [2:0]      grant_cnt_next;
  logic            timeout_next;

  logic            pick_valid;
  logic [2:0]      pick_id;
  logic            normal_end;
  logic            forced_end;

  // Rotating priority scan starting at ptr. Scanning from the far end
  // backwards lets the index closest to ptr overwrite the others.
  always_comb begin
    int         sum;
    logic [2:0] idx;
    pick_valid = 1'b0;
    pick_id    = 3'd0;
    sum        = 0;
    idx        = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = 3'(sum);
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  // A normal release wins over the timeout, so the pulse is only raised
  // when nothing else would have ended the grant on this edge.
  assign normal_end = owner_release | ~req[gnt_id];
  assign forced_end = TIMEOUT_EN & (hold_cnt == HOLD_LAST) & ~normal_end;

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    gnt_next       = gnt;
    gnt_id_next    = gnt_id;
    busy_next      = busy;
    hold_next      = hold_cnt;
    grant_cnt_next = grant_cnt;
    timeout_next   = 1'b0;

    case (state)
      IDLE, GAP: begin
        gnt_next    = '0;
        gnt_id_next = 3'd0;
        busy_next   = 1'b0;
        hold_next   = 3'd0;
        if (pick_valid) begin
          state_next     = GRANT;
          gnt_next       = ONE_HOT0 << pick_id;
          gnt_id_next    = pick_id;
          busy_next      = 1'b1;
          grant_cnt_next = grant_cnt + 3'd1;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (normal_end || forced_end) begin
          state_next   = GAP;
          gnt_next     = '0;
          gnt_id_next  = 3'd0;
          busy_next    = 1'b0;
          hold_next    = 3'd0;
          ptr_next     = (gnt_id == LAST_ID) ? 3'd0 : gnt_id + 3'd1;
          timeout_next = forced_end;
        end else begin
          hold_next = (hold_cnt == 3'd7) ? 3'd7 : hold_cnt + 3'd1;
        end
      end
      default: begin
        state_next  = IDLE;
        gnt_next    = '0;
        gnt_id_next = 3'd0;
        busy_next   = 1'b0;
        hold_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt       <= '0;
      gnt_id    <= 3'd0;
      busy      <= 1'b0;
      hold_cnt  <= 3'd0;
      grant_cnt <= 3'd0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      gnt       <= gnt_next;
      gnt_id    <= gnt_id_next;
      busy      <= busy_next;
      hold_cnt  <= hold_next;
      grant_cnt <= grant_cnt_next;
      timeout   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// tb_counter_slot_arbiter
// Self-checking bench for counter_slot_arbiter (NREQ=6, MAX_HOLD=5).
// Honours SLOT_TIMEOUT_EN the same way as the design.

module tb_counter_slot_arbiter;

  localparam int NREQ     = 6;
  localparam int MAX_HOLD = 5;

`ifdef SLOT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic            owner_release;
  logic [NREQ-1:0] gnt;
  logic [2:0]      gnt_id;
  logic            busy;
  logic [2:0]      hold_cnt;
  logic [2:0]      grant_cnt;
  logic            timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the slot (-1 = nobody), where the next
  // search starts, how long the owner has held it, how many grants so far.
  int m_owner;
  int m_ptr;
  int m_hold;
  int m_gcnt;
  int m_timeout;

  typedef struct {
    logic [NREQ-1:0] req;
    logic            rel;
    logic [NREQ-1:0] gnt;
    int              id;
    logic            busy;
    int              hold;
    int              gcnt;
  } vec_t;

  vec_t vecs[11];

  counter_slot_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .owner_release(owner_release),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .hold_cnt     (hold_cnt),
    .grant_cnt    (grant_cnt),
    .timeout      (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_hold    = 0;
    m_gcnt    = 0;
    m_timeout = 0;
  endtask

  task automatic model_step();
    bit normal;
    bit forced;
    int i;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      normal = owner_release || !req[m_owner];
      forced = TO_EN && !normal && (m_hold == MAX_HOLD - 1);
      if (normal || forced) begin
        m_ptr     = (m_owner + 1) % NREQ;
        m_owner   = -1;
        m_hold    = 0;
        m_timeout = forced ? 1 : 0;
      end else begin
        m_hold    = (m_hold >= 7) ? 7 : m_hold + 1;
        m_timeout = 0;
      end
    end else begin
      m_timeout = 0;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (req[i]) begin
          m_owner = i;
          m_hold  = 0;
          m_gcnt  = (m_gcnt + 1) % 8;
          break;
        end
      end
    end
  endtask

  task automatic check_output(input string name);
    int exp_gnt;
    exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
    check_val({name, ".gnt"},       int'(gnt),       exp_gnt);
    check_val({name, ".gnt_id"},    int'(gnt_id),    (m_owner >= 0) ? m_owner : 0);
    check_val({name, ".busy"},      int'(busy),      (m_owner >= 0) ? 1 : 0);
    check_val({name, ".hold_cnt"},  int'(hold_cnt),  m_hold);
    check_val({name, ".grant_cnt"}, int'(grant_cnt), m_gcnt);
    check_val({name, ".timeout"},   int'(timeout),   m_timeout);
  endtask

  // Drive inputs between edges, let one edge pass, then sample 1 ns later.
  task automatic apply_stimulus(input logic [NREQ-1:0] r, input logic rl, input string name);
    req           = r;
    owner_release = rl;
    @(posedge clk);
    model_step();
    #1;
    check_output(name);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string name);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_output(name);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    req           = '0;
    owner_release = 1'b0;
    model_reset();
    #12;
    check_output("reset_state");
    reset = 1'b1;

    // Expected values worked out by hand from the arbitration rules.
    vecs[0]  = '{6'b001000, 1'b0, 6'b001000, 3, 1'b1, 0, 1};
    vecs[1]  = '{6'b001000, 1'b0, 6'b001000, 3, 1'b1, 1, 1};
    vecs[2]  = '{6'b001000, 1'b1, 6'b000000, 0, 1'b0, 0, 1};
    vecs[3]  = '{6'b000110, 1'b0, 6'b000010, 1, 1'b1, 0, 2};
    vecs[4]  = '{6'b000110, 1'b1, 6'b000000, 0, 1'b0, 0, 2};
    vecs[5]  = '{6'b000110, 1'b0, 6'b000100, 2, 1'b1, 0, 3};
    vecs[6]  = '{6'b000000, 1'b0, 6'b000000, 0, 1'b0, 0, 3};
    vecs[7]  = '{6'b000000, 1'b1, 6'b000000, 0, 1'b0, 0, 3};
    vecs[8]  = '{6'b100001, 1'b1, 6'b100000, 5, 1'b1, 0, 4};
    vecs[9]  = '{6'b100001, 1'b1, 6'b000000, 0, 1'b0, 0, 4};
    vecs[10] = '{6'b100001, 1'b0, 6'b000001, 0, 1'b1, 0, 5};

    for (int v = 0; v < 11; v++) begin
      apply_stimulus(vecs[v].req, vecs[v].rel, $sformatf("vec%0d", v));
      check_val($sformatf("vec%0d.tbl_gnt", v),  int'(gnt),       int'(vecs[v].gnt));
      check_val($sformatf("vec%0d.tbl_id", v),   int'(gnt_id),    vecs[v].id);
      check_val($sformatf("vec%0d.tbl_busy", v), int'(busy),      int'(vecs[v].busy));
      check_val($sformatf("vec%0d.tbl_hold", v), int'(hold_cnt),  vecs[v].hold);
      check_val($sformatf("vec%0d.tbl_gcnt", v), int'(grant_cnt), vecs[v].gcnt);
    end

    // Asynchronous reset in the middle of a grant to requester 3.
    apply_stimulus(6'b001000, 1'b0, "rst_pre_drop");
    apply_stimulus(6'b001000, 1'b0, "rst_pre_grant");
    check_val("rst_pre.gnt_id", int'(gnt_id), 3);
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_async.gnt",       int'(gnt),       0);
    check_val("rst_async.gnt_id",    int'(gnt_id),    0);
    check_val("rst_async.busy",      int'(busy),      0);
    check_val("rst_async.grant_cnt", int'(grant_cnt), 0);
    model_reset();
    apply_stimulus(6'b001000, 1'b0, "rst_held");
    reset = 1'b1;
    apply_stimulus(6'b001000, 1'b0, "rst_after");
    check_val("rst_after.gnt", int'(gnt), 6'b001000);

    // Round robin with everyone requesting.
    pulse_reset("rr_reset");
    for (int g = 0; g < 7; g++) begin
      apply_stimulus(6'b111111, 1'b0, "rr_grant");
      check_val($sformatf("rr%0d.gnt_id", g), int'(gnt_id), g % NREQ);
      apply_stimulus(6'b111111, 1'b1, "rr_gap");
      check_val($sformatf("rr%0d.gap_gnt", g), int'(gnt), 0);
    end

    // Grant counter wraps modulo 8.
    pulse_reset("gc_reset");
    for (int g = 0; g < 9; g++) begin
      apply_stimulus(6'b111111, 1'b0, "gc_grant");
      check_val($sformatf("gc%0d.grant_cnt", g), int'(grant_cnt), (g + 1) % 8);
      apply_stimulus(6'b111111, 1'b1, "gc_gap");
    end

    // Owner drops its request; pointer moves past it.
    pulse_reset("drop_reset");
    apply_stimulus(6'b000100, 1'b0, "drop_grant");
    check_val("drop.owner", int'(gnt_id), 2);
    apply_stimulus(6'b000000, 1'b0, "drop_gap");
    check_val("drop.gap_gnt", int'(gnt), 0);
    apply_stimulus(6'b000101, 1'b0, "drop_next");
    check_val("drop.next_id", int'(gnt_id), 0);

    // Owner 4 never releases.
    pulse_reset("to_reset");
    apply_stimulus(6'b010000, 1'b0, "to_grant");
    check_val("to.owner", int'(gnt_id), 4);
    for (int c = 1; c < MAX_HOLD; c++) begin
      apply_stimulus(6'b010001, 1'b0, "to_hold");
      check_val($sformatf("to_hold%0d.busy", c), int'(busy), 1);
    end
    if (TO_EN) begin
      apply_stimulus(6'b010001, 1'b0, "to_fire");
      check_val("to_fire.timeout", int'(timeout), 1);
      check_val("to_fire.gnt", int'(gnt), 0);
      apply_stimulus(6'b010001, 1'b0, "to_next");
      check_val("to_next.timeout", int'(timeout), 0);
      check_val("to_next.gnt_id", int'(gnt_id), 0);
    end else begin
      for (int c = MAX_HOLD; c < 22; c++) begin
        apply_stimulus(6'b010001, 1'b0, "to_long");
        check_val($sformatf("to_long%0d.busy", c), int'(busy), 1);
        check_val($sformatf("to_long%0d.timeout", c), int'(timeout), 0);
      end
    end

    // Randomised traffic against the model.
    pulse_reset("rnd_reset");
    for (int n = 0; n < 400; n++) begin
      logic [NREQ-1:0] r;
      logic            rl;
      r  = ($urandom_range(2) == 0) ? NREQ'($urandom) : req;
      rl = ($urandom_range(3) == 0);
      apply_stimulus(r, rl, "rnd");
      if ($urandom_range(80) == 0) pulse_reset("rnd_async_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
